// File: rtl/fp_op_scheduler_if.sv
// Request/response and shared-resource bundle for fp_op_scheduler.
// slave: scheduler side; master: requester plus adder/multiplier/divider side.
interface fp_op_scheduler_if #(
  parameter int PRECISION = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [PRECISION-1:0] a;
  logic [PRECISION-1:0] b;
  logic                 ready;
  logic                 done;
  logic                 error;
  logic [PRECISION-1:0] result;

  logic [PRECISION-1:0] add_a;
  logic [PRECISION-1:0] add_b;
  logic                 add_op;
  logic                 add_load;
  logic                 add_valid;
  logic [PRECISION-1:0] add_out;

  logic [PRECISION-1:0] mul_a;
  logic [PRECISION-1:0] mul_b;
  logic [PRECISION-1:0] mul_result;

  logic [PRECISION-1:0] div_a;
  logic [PRECISION-1:0] div_b;
  logic                 div_load;
  logic                 div_enable;
  logic                 div_valid;
  logic [PRECISION-1:0] div_result;

  logic [PRECISION-1:0] div_add_a;
  logic [PRECISION-1:0] div_add_b;
  logic                 div_add_op;
  logic                 div_add_load;
  logic [PRECISION-1:0] div_mul_a;
  logic [PRECISION-1:0] div_mul_b;

  modport slave (
    input  start, op, a, b,
    output ready, done, error, result,
    output add_a, add_b, add_op, add_load,
    input  add_valid, add_out,
    output mul_a, mul_b,
    input  mul_result,
    output div_a, div_b, div_load, div_enable,
    input  div_valid, div_result,
    input  div_add_a, div_add_b, div_add_op, div_add_load,
    input  div_mul_a, div_mul_b
  );

  modport master (
    output start, op, a, b,
    input  ready, done, error, result,
    input  add_a, add_b, add_op, add_load,
    output add_valid, add_out,
    input  mul_a, mul_b,
    output mul_result,
    input  div_a, div_b, div_load, div_enable,
    output div_valid, div_result,
    output div_add_a, div_add_b, div_add_op, div_add_load,
    output div_mul_a, div_mul_b
  );
endinterface

// File: rtl/fp_op_scheduler.sv
// Sequences add/sub/mul/div onto a shared FP adder, multiplier and divider.
// Ports: clk; rst (async, active-high); bus (fp_op_scheduler_if.slave).
module fp_op_scheduler #(
  parameter int PRECISION = 32,
  parameter int TIMEOUT   = 64
) (
  input logic              clk,
  input logic              rst,
  fp_op_scheduler_if.slave bus
);
  localparam int W  = PRECISION;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] NAN = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, ADD_LOAD, ADD_WAIT, MUL_DRIVE,
    MUL_CAP, DIV_LOAD, DIV_RUN, DONE
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q;
  logic [W-1:0]  result_q, result_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt;
  logic          tmo;
  logic          accept;

  assign accept = (state == IDLE) && bus.start;
  // Last permitted wait cycle; a valid here still wins.
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        sub_q <= bus.op[0];
      end
      if (state == ADD_WAIT || state == DIV_RUN)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

  always_comb begin
    state_d  = state;
    result_d = result_q;
    err_d    = err_q;
    unique case (state)
      IDLE: begin
        err_d = 1'b0;
        if (bus.start) begin
          unique case (bus.op)
            2'b10:   state_d = MUL_DRIVE;
            2'b11:   state_d = DIV_LOAD;
            default: state_d = ADD_LOAD;
          endcase
        end
      end
      ADD_LOAD:  state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (bus.add_valid) begin
          result_d = bus.add_out;
          state_d  = DONE;
        end else if (tmo) begin
          result_d = NAN;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      MUL_DRIVE: state_d = MUL_CAP;
      MUL_CAP: begin
        result_d = bus.mul_result;
        state_d  = DONE;
      end
      DIV_LOAD:  state_d = DIV_RUN;
      DIV_RUN: begin
        if (bus.div_valid) begin
          result_d = bus.div_result;
          state_d  = DONE;
        end else if (tmo) begin
          result_d = NAN;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready      = (state == IDLE);
    bus.done       = (state == DONE);
    bus.error      = (state == DONE) && err_q;
    bus.result     = result_q;
    bus.add_a      = '0;
    bus.add_b      = '0;
    bus.add_op     = 1'b0;
    bus.add_load   = 1'b0;
    bus.mul_a      = '0;
    bus.mul_b      = '0;
    bus.div_a      = '0;
    bus.div_b      = '0;
    bus.div_load   = 1'b0;
    bus.div_enable = 1'b0;
    unique case (state)
      ADD_LOAD, ADD_WAIT: begin
        bus.add_a    = a_q;
        bus.add_b    = b_q;
        bus.add_op   = sub_q;
        bus.add_load = (state == ADD_LOAD);
      end
      MUL_DRIVE: begin
        bus.mul_a = a_q;
        bus.mul_b = b_q;
      end
      DIV_LOAD: begin
        bus.div_a      = a_q;
        bus.div_b      = b_q;
        bus.div_load   = 1'b1;
        bus.div_enable = 1'b1;
      end
      DIV_RUN: begin
        // Divider owns the shared adder and multiplier while it runs.
        bus.div_a      = a_q;
        bus.div_b      = b_q;
        bus.div_enable = 1'b1;
        bus.add_a      = bus.div_add_a;
        bus.add_b      = bus.div_add_b;
        bus.add_op     = bus.div_add_op;
        bus.add_load   = bus.div_add_load;
        bus.mul_a      = bus.div_mul_a;
        bus.mul_b      = bus.div_mul_b;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_fp_op_scheduler.sv
// Randomized scoreboard bench for fp_op_scheduler with FP resource models.
// Ports: none; drives the scheduler interface and models adder/mul/divider.
module tb_fp_op_scheduler;
  localparam int W   = 32;
  localparam int TMO = 64;
  localparam logic [31:0] NAN = 32'h7FFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_op_scheduler_if #(.PRECISION(W)) bus();

  fp_op_scheduler #(
    .PRECISION(W),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_issued = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'b0};
    else d = {f[31], ({3'b0, f[30:23]} + 11'd896), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [30:0] em;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    e = d[62:52] - 11'd896;
    em = {e[7:0], d[51:29]} + {30'b0, d[28]};
    return {d[63], em};
  endfunction

  function automatic logic [31:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    real x;
    real y;
    real z;
    x = f2r(a);
    y = f2r(b);
    case (op)
      2'd0:    z = x + y;
      2'd1:    z = x - y;
      2'd2:    z = x * y;
      default: z = x / y;
    endcase
    return r2f(z);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Adder model: result valid add_lat cycles after the load cycle ends.
  int          add_lat = 4;
  int          add_cnt = 0;
  logic        add_pend = 1'b0;
  logic [31:0] add_s = '0;
  logic        add_stall = 1'b0;
  logic        force_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      add_pend <= 1'b0;
      add_cnt  <= 0;
      add_s    <= '0;
    end else if (bus.add_load) begin
      add_s <= bus.add_op ? r2f(f2r(bus.add_a) - f2r(bus.add_b))
                          : r2f(f2r(bus.add_a) + f2r(bus.add_b));
      add_cnt  <= add_lat;
      add_pend <= 1'b1;
    end else if (add_pend) begin
      if (add_cnt == 0) add_pend <= 1'b0;
      else add_cnt <= add_cnt - 1;
    end
  end

  assign bus.add_valid = (add_pend && add_cnt == 0 && !add_stall)
                         || force_valid;
  assign bus.add_out = force_valid ? 32'hDEADBEEF : add_s;

  logic [31:0] mul_r = '0;
  always @(posedge clk)
    mul_r <= rst ? 32'h0 : r2f(f2r(bus.mul_a) * f2r(bus.mul_b));
  assign bus.mul_result = mul_r;

  // Divider model: q = (2a * 1/b) - (2a * 1/b)/2, via shared mul and adder.
  int          dv_ph = 0;
  logic [31:0] dv_a = '0;
  logic [31:0] dv_b = '0;
  logic [31:0] dv_q = '0;
  logic [31:0] dv_add_a, dv_add_b, dv_mul_a, dv_mul_b;
  logic        dv_add_op, dv_add_load;

  always @(posedge clk) begin
    if (rst || !bus.div_enable) begin
      dv_ph <= 0;
    end else if (bus.div_load) begin
      dv_a  <= bus.div_a;
      dv_b  <= bus.div_b;
      dv_ph <= 1;
    end else begin
      case (dv_ph)
        1: dv_ph <= 2;
        2: begin dv_q <= bus.mul_result; dv_ph <= 3; end
        3: dv_ph <= 4;
        4: if (bus.add_valid) begin dv_q <= bus.add_out; dv_ph <= 5; end
        5: dv_ph <= 0;
        default: dv_ph <= 0;
      endcase
    end
  end

  always_comb begin
    dv_add_a    = '0;
    dv_add_b    = '0;
    dv_add_op   = 1'b0;
    dv_add_load = 1'b0;
    dv_mul_a    = '0;
    dv_mul_b    = '0;
    if (dv_ph == 1) begin
      dv_mul_a = r2f(2.0 * f2r(dv_a));
      dv_mul_b = r2f(1.0 / f2r(dv_b));
    end
    if (dv_ph == 3) begin
      dv_add_a    = dv_q;
      dv_add_b    = r2f(0.5 * f2r(dv_q));
      dv_add_op   = 1'b1;
      dv_add_load = 1'b1;
    end
  end

  assign bus.div_add_a    = dv_add_a;
  assign bus.div_add_b    = dv_add_b;
  assign bus.div_add_op   = dv_add_op;
  assign bus.div_add_load = dv_add_load;
  assign bus.div_mul_a    = dv_mul_a;
  assign bus.div_mul_b    = dv_mul_b;
  assign bus.div_valid    = (dv_ph == 5) || force_valid;
  assign bus.div_result   = force_valid ? 32'hBADC0DE0 : dv_q;

  // Monitor: every done pulse retires the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done) begin
        n_done++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", {32'h0, bus.result}, {32'h0, e.res});
          chk("error", {63'h0, bus.error}, {63'h0, e.err});
        end else begin
          total++;
          bad++;
          $display("FAIL spurious_done: done=1 with nothing pending");
        end
      end else begin
        chk("error_no_done", {63'h0, bus.error}, 64'h0);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input logic ee, input int exp_lat,
                        input int busy_at);
    int lat;
    bit seen;
    lat = 0;
    seen = 0;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    sb.push_back('{res: er, err: ee});
    n_issued++;
    while (lat < 400 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (lat == busy_at) begin
        chk("busy_ready", {63'h0, bus.ready}, 64'h0);
        bus.start = 1'b1;
        bus.op = 2'd2;
        bus.a = 32'h41200000;
      end
      if (lat == busy_at + 1 && busy_at > 0) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1;
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        chk("done_div_en", {63'h0, bus.div_enable}, 64'h0);
      end else begin
        chk("busy_not_ready", {63'h0, bus.ready}, 64'h0);
        case (op)
          2'd0, 2'd1: begin
            chk("add_load", {63'h0, bus.add_load}, {63'h0, lat == 1});
            chk("add_a", {32'h0, bus.add_a}, {32'h0, a});
            chk("add_b", {32'h0, bus.add_b}, {32'h0, b});
            chk("add_op", {63'h0, bus.add_op}, {63'h0, op[0]});
            chk("add_div_en", {63'h0, bus.div_enable}, 64'h0);
          end
          2'd2: begin
            chk("mul_a", {32'h0, bus.mul_a}, {32'h0, lat == 1 ? a : 32'h0});
            chk("mul_b", {32'h0, bus.mul_b}, {32'h0, lat == 1 ? b : 32'h0});
          end
          default: begin
            chk("div_enable", {63'h0, bus.div_enable}, 64'h1);
            chk("div_load", {63'h0, bus.div_load}, {63'h0, lat == 1});
            if (lat == 1) begin
              chk("div_a", {32'h0, bus.div_a}, {32'h0, a});
              chk("div_b", {32'h0, bus.div_b}, {32'h0, b});
            end else begin
              chk("gr_add_a", {32'h0, bus.add_a}, {32'h0, dv_add_a});
              chk("gr_add_b", {32'h0, bus.add_b}, {32'h0, dv_add_b});
              chk("gr_add_op", {63'h0, bus.add_op}, {63'h0, dv_add_op});
              chk("gr_add_ld", {63'h0, bus.add_load}, {63'h0, dv_add_load});
              chk("gr_mul_a", {32'h0, bus.mul_a}, {32'h0, dv_mul_a});
              chk("gr_mul_b", {32'h0, bus.mul_b}, {32'h0, dv_mul_b});
            end
          end
        endcase
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL no_done: op=%0d no done within %0d cycles", op, lat);
    end
    @(negedge clk);
    chk("done_pulse", {63'h0, bus.done}, 64'h0);
    chk("ready_after", {63'h0, bus.ready}, 64'h1);
    chk("result_hold", {32'h0, bus.result}, {32'h0, er});
  endtask

  function automatic logic [31:0] rnd_int();
    int v;
    v = int'($urandom_range(0, 40)) - 20;
    return r2f(real'(v));
  endfunction

  function automatic logic [31:0] rnd_nz();
    int v;
    v = int'($urandom_range(1, 20));
    if ($urandom_range(0, 1) == 1) v = -v;
    return r2f(real'(v));
  endfunction

  function automatic logic [31:0] rnd_pow2();
    real r;
    int k;
    r = 1.0;
    k = int'($urandom_range(0, 6)) - 3;
    for (int i = 0; i < 3; i++) begin
      if (k > i) r = r * 2.0;
      if (-k > i) r = r * 0.5;
    end
    if ($urandom_range(0, 1) == 1) r = -r;
    return r2f(r);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          el;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'h0, bus.ready}, 64'h1);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_error", {63'h0, bus.error}, 64'h0);
    chk("rst_result", {32'h0, bus.result}, 64'h0);
    chk("rst_add_load", {63'h0, bus.add_load}, 64'h0);
    chk("rst_div_en", {63'h0, bus.div_enable}, 64'h0);
    rst = 1'b0;

    force_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", {63'h0, bus.ready}, 64'h1);
      chk("idle_result", {32'h0, bus.result}, 64'h0);
    end
    force_valid = 1'b0;
    @(negedge clk);

    add_lat = 4;
    run_op(2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 7, 0);
    run_op(2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 3, 0);
    run_op(2'd3, 32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, -1, 0);
    run_op(2'd0, 32'h40A00000, 32'h3F800000, 32'h40C00000, 1'b0, 7, 3);

    add_stall = 1'b1;
    run_op(2'd0, 32'h3F800000, 32'h40000000, NAN, 1'b1, TMO + 2, 0);
    add_stall = 1'b0;
    add_lat = TMO - 1;
    run_op(2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0,
           TMO + 2, 0);
    add_lat = TMO;
    run_op(2'd1, 32'h3F800000, 32'h40000000, NAN, 1'b1, TMO + 2, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      add_lat = int'($urandom_range(1, 10));
      if (op == 2'd3) begin
        a = rnd_nz();
        b = rnd_pow2();
      end else begin
        a = rnd_int();
        b = rnd_int();
      end
      el = (op == 2'd2) ? 3 : (op == 2'd3) ? -1 : add_lat + 3;
      run_op(op, a, b, ref_op(op, a, b), 1'b0, el, 0);
    end

    add_lat = 4;
    bus.op = 2'd3;
    bus.a = 32'h40C00000;
    bus.b = 32'h40400000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_div_en", {63'h0, bus.div_enable}, 64'h1);
    chk("mid_div_gr", {63'h0, bus.add_load}, 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("rd_div_en", {63'h0, bus.div_enable}, 64'h0);
    chk("rd_add_load", {63'h0, bus.add_load}, 64'h0);
    chk("rd_add_a", {32'h0, bus.add_a}, 64'h0);
    chk("rd_mul_a", {32'h0, bus.mul_a}, 64'h0);
    chk("rd_mul_b", {32'h0, bus.mul_b}, 64'h0);
    chk("rd_ready", {63'h0, bus.ready}, 64'h1);
    chk("rd_done", {63'h0, bus.done}, 64'h0);
    chk("rd_result", {32'h0, bus.result}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd2, 32'h40400000, 32'h40800000, 32'h41400000, 1'b0, 3, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 64'h0);
    chk("done_count", n_done, n_issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_op_scheduler.md
FP_OP_SCHEDULER -- requirements
Module: fp_op_scheduler

Interface
REQ-001 Parameters SHALL be: PRECISION, 32, operand width (32 or 64); TIMEOUT, 64, maximum wait cycles for adder or divider completion.
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Start, Op  in  1, 2  request strobe; Op 00=add, 01=sub, 10=mul, 11=div.
REQ-005 A, B  in  PRECISION  request operands.
REQ-006 Ready, Done, Error  out  1  idle flag; one-cycle completion pulse; one-cycle timeout pulse.
REQ-007 Result  out  PRECISION  last completed result.
REQ-008 AddA, AddB, AddOp, AddLoad  out  PRECISION, PRECISION, 1, 1  shared adder controls.
REQ-009 AddValid, AddOut  in  1, PRECISION  shared adder status and sum.
REQ-010 MulA, MulB  out  PRECISION  shared multiplier operands; MulResult  in  PRECISION  product, valid one cycle after operands.
REQ-011 DivA, DivB, DivLoad, DivEnable  out  PRECISION, PRECISION, 1, 1  divider operands and controls.
REQ-012 DivValid, DivResult  in  1, PRECISION  divider status and quotient.
REQ-013 DivAddA, DivAddB, DivAddOp, DivAddLoad, DivMulA, DivMulB  in  divider requests for the shared adder and multiplier, same widths as REQ-008/REQ-010.

Function
REQ-014 States SHALL be IDLE, ADD_LOAD, ADD_WAIT, MUL_DRIVE, MUL_CAP, DIV_LOAD, DIV_RUN, DONE.
REQ-015 Ready SHALL be 1 only in IDLE; Start while Ready=0 SHALL be ignored with no state change.
REQ-016 In IDLE with Start=1: A, B, Op SHALL be registered. Next state: Op 00/01 -> ADD_LOAD, 10 -> MUL_DRIVE, 11 -> DIV_LOAD.
REQ-017 ADD_LOAD SHALL drive AddA=A, AddB=B, AddOp=Op[0], AddLoad=1 for exactly one cycle, then go to ADD_WAIT.
REQ-018 ADD_WAIT SHALL hold AddA, AddB and AddOp with AddLoad=0. On AddValid=1 it SHALL capture AddOut into Result and go to DONE.
REQ-019 MUL_DRIVE SHALL drive MulA=A, MulB=B for one cycle. MUL_CAP SHALL capture MulResult into Result and go to DONE.
REQ-020 DIV_LOAD SHALL drive DivA=A, DivB=B, DivLoad=1, DivEnable=1 for one cycle, then go to DIV_RUN.
REQ-021 DIV_RUN SHALL hold DivEnable=1 and DivLoad=0 and grant both resources to the divider (Add*=DivAdd*, Mul*=DivMul*). On DivValid=1 it SHALL capture DivResult into Result and go to DONE.
REQ-022 Outside DIV_LOAD/DIV_RUN, DivEnable SHALL be 0. In any state not driving a resource, that resource's operands and controls SHALL be zero.
REQ-023 DONE SHALL assert Done=1 for one cycle and then return to IDLE. Result SHALL hold until the next capture.
REQ-024 A wait counter SHALL clear on entering ADD_WAIT/DIV_RUN and increment each cycle there. When it reaches TIMEOUT without a valid: Result=NaN (0, exponent all ones, mantissa all ones), Error=1 and Done=1 in the same DONE cycle.
REQ-025 A valid arriving on the same cycle the counter reaches TIMEOUT SHALL take priority; no Error is raised.
REQ-026 Latency (Start to Done) SHALL be 3 cycles for mul, adder-latency+3 for add/sub, and divider-latency+3 for div.

Reset
REQ-027 Reset=1 SHALL immediately force IDLE, Ready=1, Done=0, Error=0, Result=0, wait counter=0, and all resource and divider outputs to 0, including mid-operation.
REQ-028 After Reset deasserts, the first Start SHALL be accepted normally; pending resource valids SHALL be ignored in IDLE.

Verification
REQ-029 Add: Op=00, A=0x3F800000, B=0x40000000, with an adder model of 4-cycle latency -> Done after 7 cycles, Result=0x40400000, Error=0.
REQ-030 Mul: Op=10, A=0x3FC00000, B=0x40000000 -> Done on the 3rd cycle after Start, Result=0x40400000.
REQ-031 Div: Op=11, A=0x40C00000, B=0x40400000, with a real divider, adder and multiplier -> Result=0x40000000. Bench SHALL check DivEnable=1 throughout DIV_RUN and the resource grant during it.
REQ-032 Busy: second Start (Op=10) during ADD_WAIT -> ignored; only one Done pulse; Result = adder result.
REQ-033 Timeout: Op=00 with AddValid tied 0 -> after TIMEOUT=64 wait cycles, Done=1, Error=1, Result=0x7FFFFFFF.
REQ-034 Reset mid-div: Reset asserted in DIV_RUN -> same-cycle DivEnable=0, Mul*/Add* outputs 0, Ready=1. A subsequent mul completes correctly.
